// File: rtl/fetch_defs.sv
// rtl/fetch_defs.sv - shared state encodings and default widths for the fetch queue
package fetch_defs;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } fetch_state_t;

    localparam int DEF_PC_W    = 16;
    localparam int DEF_INSTR_W = 9;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - power-of-two circular buffer with synchronous flush and count
module fetch_fifo #(
    parameter int WIDTH = 25,
    parameter int DEPTH = 4,
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [CW-1:0]    count
);

    localparam logic [AW-1:0] PTR_MASK = AW'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             empty;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty     = (count == '0);
    assign full      = (count == CW'(DEPTH));
    assign do_pop    = pop & !empty;
    // A push into a full queue is only taken when the head leaves in the same cycle.
    assign do_push   = push & (!full | do_pop);
    assign head_data = mem[rd_ptr];

    // Storage write; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and count update; flush empties the queue in one cycle.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr + 1'b1) & PTR_MASK;
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr + 1'b1) & PTR_MASK;
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // The credit logic upstream must never deliver data into a full queue.
    always_ff @(posedge clk) begin
        if (!reset && !flush) begin
            assert (!(push && full))
                else $error("fetch_fifo: push while full");
        end
    end

endmodule

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - prefetching fetch unit with credit-limited queue toward decode
module fetch_queue
    import fetch_defs::*;
#(
    parameter int              PC_W     = DEF_PC_W,
    parameter int              INSTR_W  = DEF_INSTR_W,
    parameter int              DEPTH    = 4,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [PC_W-1:0]            start_pc,
    input  logic                       redirect,
    input  logic [PC_W-1:0]            redirect_target,
    output logic                       imem_req,
    output logic [PC_W-1:0]            imem_addr,
    input  logic [INSTR_W-1:0]         imem_rdata,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [PC_W-1:0]            out_pc,
    output logic [INSTR_W-1:0]         out_instr,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);

    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam int ENT_W = PC_W + INSTR_W;

    fetch_state_t      state_q;
    fetch_state_t      state_d;
    logic [PC_W-1:0]   fetch_pc;
    logic [PC_W-1:0]   fetch_pc_d;
    logic              inflight_q;
    logic [PC_W-1:0]   inflight_pc_q;
    logic              flush;
    logic              pop;
    logic              push;
    logic [OCC_W:0]    pending;
    logic              credit_ok;
    logic [ENT_W-1:0]  head_data;

    assign pop       = out_valid & out_ready;
    // Entries the queue will hold after this edge, counting the response now arriving.
    assign pending   = {1'b0, occupancy} + (OCC_W + 1)'(inflight_q) - (OCC_W + 1)'(pop);
    assign credit_ok = pending < (OCC_W + 1)'(DEPTH);
    // A start or redirect in the response cycle kills that response.
    assign push      = inflight_q & !flush;

    assign imem_addr = fetch_pc;
    assign out_valid = (occupancy != '0);
    assign {out_pc, out_instr} = out_valid ? head_data : '0;

    // Next state, next fetch PC, request and flush decisions in priority order.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc;
        imem_req   = 1'b0;
        flush      = 1'b0;
        if (start) begin
            state_d    = RUN;
            fetch_pc_d = start_pc;
            flush      = 1'b1;
        end else if (state_q == RUN && redirect) begin
            fetch_pc_d = redirect_target;
            flush      = 1'b1;
        end else if (state_q == RUN && credit_ok) begin
            imem_req   = 1'b1;
            fetch_pc_d = fetch_pc + 1'b1;
        end
    end

    // State, fetch PC and in-flight tracking registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            fetch_pc      <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc   <= fetch_pc_d;
            inflight_q <= imem_req;
            if (imem_req) begin
                inflight_pc_q <= fetch_pc;
            end
        end
    end

    fetch_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .push      (push),
        .push_data ({inflight_pc_q, imem_rdata}),
        .pop       (pop),
        .head_data (head_data),
        .count     (occupancy)
    );

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - directed self-checking bench for fetch_queue
module tb_fetch_queue;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] start_pc;
    logic        redirect;
    logic [15:0] redirect_target;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic [8:0]  imem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_pc;
    logic [8:0]  out_instr;
    logic [2:0]  occupancy;

    int total = 0;
    int bad   = 0;

    fetch_queue #(
        .PC_W     (16),
        .INSTR_W  (9),
        .DEPTH    (4),
        .RESET_PC (16'h0000)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .start_pc        (start_pc),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_rdata      (imem_rdata),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_pc          (out_pc),
        .out_instr       (out_instr),
        .occupancy       (occupancy)
    );

    always #5 clk = ~clk;

    function automatic logic [8:0] mem_of(input logic [15:0] a);
        return a[8:0] ^ 9'h155;
    endfunction

    // Instruction memory: one-cycle synchronous read; data keeps changing regardless of requests.
    always @(posedge clk) begin
        if (imem_req) imem_rdata <= mem_of(imem_addr);
        else          imem_rdata <= imem_rdata + 9'h023;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; start_pc = '0; redirect = 1'b0;
        redirect_target = '0; out_ready = 1'b0; imem_rdata = 9'h0AA;
        cyc(); cyc();
        reset = 1'b0;
        #1;
        total++;
        if (imem_req !== 1'b0 || out_valid !== 1'b0 || occupancy !== 3'd0 ||
            imem_addr !== 16'h0000 || out_pc !== 16'h0000 || out_instr !== 9'h000)
            begin bad++; $display("FAIL reset_values req=%0b valid=%0b occ=%0d addr=%h pc=%h instr=%h exp 0", imem_req, out_valid, occupancy, imem_addr, out_pc, out_instr); end
        for (int k = 0; k < 5; k++) begin
            redirect = (k == 2);
            redirect_target = 16'h0099;
            cyc();
            #1;
            total++;
            if (imem_req !== 1'b0 || out_valid !== 1'b0 || occupancy !== 3'd0 || imem_addr !== 16'h0000)
                begin bad++; $display("FAIL idle k=%0d req=%0b valid=%0b occ=%0d addr=%h exp 0,0,0,0000", k, imem_req, out_valid, occupancy, imem_addr); end
        end
        redirect = 1'b0;
    endtask

    task automatic test_stream();
        start = 1'b1; start_pc = 16'h0000; out_ready = 1'b1;
        #1;
        total++;
        if (imem_req !== 1'b0) begin bad++; $display("FAIL stream_start_noreq got=%0b exp=0", imem_req); end
        for (int k = 1; k <= 5; k++) begin
            cyc();
            start = 1'b0;
            #1;
            if (k <= 4) begin
                total++;
                if (imem_req !== 1'b1 || imem_addr !== 16'(k - 1))
                    begin bad++; $display("FAIL stream_addr k=%0d req=%0b addr=%h exp 1,%h", k, imem_req, imem_addr, 16'(k - 1)); end
            end
            if (k >= 3) begin
                total++;
                if (out_valid !== 1'b1 || out_pc !== 16'(k - 3) || out_instr !== mem_of(16'(k - 3)))
                    begin bad++; $display("FAIL stream_out k=%0d valid=%0b pc=%h instr=%h exp 1,%h,%h", k, out_valid, out_pc, out_instr, 16'(k - 3), mem_of(16'(k - 3))); end
            end else begin
                total++;
                if (out_valid !== 1'b0) begin bad++; $display("FAIL stream_latency k=%0d valid=%0b exp 0", k, out_valid); end
            end
        end
    endtask

    task automatic test_backpressure();
        start = 1'b1; start_pc = 16'h0010; out_ready = 1'b0;
        cyc();
        start = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            #1;
            total++;
            if (occupancy > 3'd4 || (out_valid === 1'b1 && out_pc !== 16'h0010))
                begin bad++; $display("FAIL bp_hold k=%0d occ=%0d pc=%h exp occ<=4 pc=0010", k, occupancy, out_pc); end
            if (k == 4) begin
                total++;
                if (imem_req !== 1'b1 || imem_addr !== 16'h0013)
                    begin bad++; $display("FAIL bp_last_req req=%0b addr=%h exp 1,0013", imem_req, imem_addr); end
            end
            if (k >= 5) begin
                total++;
                if (imem_req !== 1'b0) begin bad++; $display("FAIL bp_credit k=%0d req=%0b exp 0", k, imem_req); end
            end
            cyc();
        end
        #1;
        total++;
        if (occupancy !== 3'd4 || imem_req !== 1'b0 || out_pc !== 16'h0010)
            begin bad++; $display("FAIL bp_full occ=%0d req=%0b pc=%h exp 4,0,0010", occupancy, imem_req, out_pc); end
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            total++;
            if (out_valid !== 1'b1 || out_pc !== 16'(16'h0010 + i) || out_instr !== mem_of(16'(16'h0010 + i)))
                begin bad++; $display("FAIL bp_drain i=%0d valid=%0b pc=%h instr=%h exp 1,%h,%h", i, out_valid, out_pc, out_instr, 16'(16'h0010 + i), mem_of(16'(16'h0010 + i))); end
            cyc();
        end
    endtask

    task automatic test_redirect();
        start = 1'b1; start_pc = 16'h0020; out_ready = 1'b0;
        cyc();
        start = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            #1;
            if (k == 4) begin
                total++;
                if (imem_req !== 1'b1 || imem_addr !== 16'h0023)
                    begin bad++; $display("FAIL redir_inflight req=%0b addr=%h exp 1,0023", imem_req, imem_addr); end
            end
            cyc();
        end
        total++;
        if (occupancy !== 3'd3) begin bad++; $display("FAIL redir_preocc occ=%0d exp 3", occupancy); end
        redirect = 1'b1; redirect_target = 16'h0004; out_ready = 1'b1;
        #1;
        total++;
        if (imem_req !== 1'b0) begin bad++; $display("FAIL redir_noreq req=%0b exp 0", imem_req); end
        cyc();
        redirect = 1'b0;
        #1;
        total++;
        if (occupancy !== 3'd0 || out_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 16'h0004)
            begin bad++; $display("FAIL redir_flush occ=%0d valid=%0b req=%0b addr=%h exp 0,0,1,0004", occupancy, out_valid, imem_req, imem_addr); end
        cyc();
        total++;
        if (out_valid !== 1'b0 || imem_addr !== 16'h0005)
            begin bad++; $display("FAIL redir_stale valid=%0b addr=%h exp 0,0005", out_valid, imem_addr); end
        cyc();
        total++;
        if (out_valid !== 1'b1 || out_pc !== 16'h0004 || out_instr !== mem_of(16'h0004))
            begin bad++; $display("FAIL redir_first valid=%0b pc=%h instr=%h exp 1,0004,%h", out_valid, out_pc, out_instr, mem_of(16'h0004)); end
        cyc();
        total++;
        if (out_valid !== 1'b1 || out_pc !== 16'h0005)
            begin bad++; $display("FAIL redir_second valid=%0b pc=%h exp 1,0005", out_valid, out_pc); end
    endtask

    task automatic test_wrap();
        start = 1'b1; start_pc = 16'hFFFE; out_ready = 1'b1;
        cyc();
        start = 1'b0;
        cyc(); cyc();
        for (int i = 0; i < 3; i++) begin
            total++;
            if (out_valid !== 1'b1 || out_pc !== 16'(16'hFFFE + i) || out_instr !== mem_of(16'(16'hFFFE + i)))
                begin bad++; $display("FAIL wrap i=%0d valid=%0b pc=%h exp 1,%h", i, out_valid, out_pc, 16'(16'hFFFE + i)); end
            cyc();
        end
    endtask

    task automatic test_reset_mid_and_priority();
        start = 1'b1; start_pc = 16'h0030; out_ready = 1'b0;
        cyc();
        start = 1'b0;
        for (int k = 0; k < 7; k++) cyc();
        total++;
        if (occupancy !== 3'd4) begin bad++; $display("FAIL rst_prefull occ=%0d exp 4", occupancy); end
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        #1;
        total++;
        if (imem_req !== 1'b0 || out_valid !== 1'b0 || occupancy !== 3'd0 ||
            imem_addr !== 16'h0000 || out_pc !== 16'h0000 || out_instr !== 9'h000)
            begin bad++; $display("FAIL rst_mid req=%0b valid=%0b occ=%0d addr=%h pc=%h instr=%h exp 0", imem_req, out_valid, occupancy, imem_addr, out_pc, out_instr); end
        cyc();
        total++;
        if (out_valid !== 1'b0 || occupancy !== 3'd0 || imem_req !== 1'b0)
            begin bad++; $display("FAIL rst_late valid=%0b occ=%0d req=%0b exp 0,0,0", out_valid, occupancy, imem_req); end
        start = 1'b1; start_pc = 16'h0060; out_ready = 1'b1;
        cyc();
        start = 1'b0;
        cyc(); cyc(); cyc();
        start = 1'b1; start_pc = 16'h0040; redirect = 1'b1; redirect_target = 16'h0050;
        #1;
        total++;
        if (imem_req !== 1'b0) begin bad++; $display("FAIL prio_noreq req=%0b exp 0", imem_req); end
        cyc();
        start = 1'b0; redirect = 1'b0;
        #1;
        total++;
        if (imem_req !== 1'b1 || imem_addr !== 16'h0040 || out_valid !== 1'b0)
            begin bad++; $display("FAIL prio_addr req=%0b addr=%h valid=%0b exp 1,0040,0", imem_req, imem_addr, out_valid); end
        cyc(); cyc();
        total++;
        if (out_valid !== 1'b1 || out_pc !== 16'h0040 || out_instr !== mem_of(16'h0040))
            begin bad++; $display("FAIL prio_out valid=%0b pc=%h exp 1,0040", out_valid, out_pc); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_wrap();
        test_reset_mid_and_priority();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Parametrised successor to the single-cycle fetch unit. It adds a prefetch queue between instruction memory and decode, so sequential fetch runs one instruction per cycle and decode can stall through a valid/ready handshake. A downstream branch redirect flushes all queued and in-flight work. Sits between instruction memory (1-cycle synchronous read) and the decode stage.

## Interface
- PC_W, 16, program counter width
- INSTR_W, 9, instruction width
- DEPTH, 4, queue entries; power of two, ≥2
- RESET_PC, 0, fetch PC loaded by reset
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  begin/restart fetching at start_pc
- start_pc  in  PC_W  restart address
- redirect  in  1  taken branch resolved downstream
- redirect_target  in  PC_W  branch target
- imem_req  out  1  read request this cycle
- imem_addr  out  PC_W  read address; meaningful when imem_req=1
- imem_rdata  in  INSTR_W  read data for the request issued the previous cycle
- out_valid  out  1  queue head valid
- out_ready  in  1  decode accepts head
- out_pc  out  PC_W  PC of head instruction
- out_instr  out  INSTR_W  head instruction
- occupancy  out  $clog2(DEPTH+1)  entries currently queued

## Operation
- States: IDLE, RUN.
  - Reset → IDLE, fetch_pc=RESET_PC, queue empty, in-flight cleared.
  - IDLE: no requests; redirect ignored.
  - start → RUN from either state.
- Priority: reset > start > redirect > normal fetch.
- start: fetch_pc←start_pc; queue flushed; in-flight response killed; no request that cycle.
- redirect (RUN only): fetch_pc←redirect_target; queue flushed; in-flight response killed; no request that cycle. A pop in the same cycle is discarded.
- Request condition: imem_req = RUN & !start & !redirect & (occupancy + inflight − pop < DEPTH).
  - pop = out_valid & out_ready.
  - imem_addr = fetch_pc.
  - On request: fetch_pc←fetch_pc+1, modulo 2^PC_W; 16'hFFFF wraps to 0.
- Response: the cycle after a request, {pc, imem_rdata} is pushed, unless it was killed.
- Overflow cannot occur by construction. Assertion: no push when full.
- Head: out_valid = occupancy≠0. out_pc and out_instr are the head entry; they hold stable while out_valid & !out_ready.
- Same-cycle push and pop at full or empty is legal; occupancy is unchanged.

## Timing
- Reset values: imem_req=0, imem_addr=RESET_PC, out_valid=0, out_pc=0, out_instr=0, occupancy=0.
- start sampled at edge E0:
  - request for start_pc during the cycle after E0
  - data pushed at E2
  - out_valid=1 after E2
  - start-to-valid latency is 2 cycles
- Redirect-to-valid latency is 2 cycles, identical to start.
- Throughput: 1 instruction/cycle with out_ready held high, for any DEPTH≥2.
- After out_ready drops, at most DEPTH entries accumulate; requests stop when the credit is exhausted.
- Reset mid-operation: all outputs return to reset values on the next edge; a late imem_rdata is ignored.

## Structure
- Shared package/defs file fetch_defs holds the state encodings (IDLE, RUN) and the default widths PC_W=16, INSTR_W=9.
- Sub-module fetch_fifo holds the storage:
  - parametrised width PC_W+INSTR_W and DEPTH
  - synchronous flush
  - pointer wrap by power-of-two masking
  - count output
- Top level holds the FSM, fetch_pc, in-flight/kill flag and credit logic.

## Test plan
- Reset then idle for 5 cycles → imem_req=0, out_valid=0, occupancy=0.
- start with start_pc=0 and out_ready=1 → imem_addr sequence 0,1,2,3; out_pc 0,1,2 from the 2nd cycle after start; out_instr matches memory.
- out_ready=0 for 8 cycles with DEPTH=4 → occupancy saturates at 4; imem_req stops; out_pc held at the same value; release → drains in order with no gaps or duplicates.
- redirect to 16'h0004 while 3 entries are queued and one request is in flight → occupancy=0 next cycle; first out_pc=4, then 5; no stale entry appears.
- start_pc=16'hFFFE → out_pc sequence FFFE, FFFF, 0000.
- reset asserted while full, and start with redirect in the same cycle → reset clears everything; start wins over redirect (fetch resumes at start_pc).
